// File: rtl/lfm_pkg.sv
// Shared constants and FSM encoding for the pulsed LFM phase generator.
package lfm_pkg;

    localparam int ROM_DEPTH   = 2048;
    localparam int ADDR_W_DEF  = $clog2(ROM_DEPTH);
    localparam int PHASE_W_DEF = 32;
    localparam int CNT_W_DEF   = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PULSE = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

endpackage

// File: rtl/lfm_phase_acc.sv
// Purpose: quadratic phase accumulator (freq ramps by k, phase integrates freq).
// Latency: phase updates the clock after load/en; phase_nxt is its combinational next value.
// Backpressure: none; runs every enabled clock.
module lfm_phase_acc #(
    parameter int PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [PHASE_W-1:0] f0,
    input  logic [PHASE_W-1:0] k,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] phase_nxt
);

    logic [PHASE_W-1:0] freq;
    logic [PHASE_W-1:0] freq_nxt;

    always_comb begin
        phase_nxt = phase;
        freq_nxt  = freq;
        if (load) begin
            phase_nxt = '0;
            freq_nxt  = f0;
        end else if (en) begin
            phase_nxt = phase + freq;
            freq_nxt  = freq + k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            freq  <= '0;
        end else begin
            phase <= phase_nxt;
            freq  <= freq_nxt;
        end
    end

endmodule

// File: rtl/lfm_pulse_addr_gen.sv
// Purpose: pulsed chirp ROM-address generator with PRT timing and DAC-enable strobe.
// Latency: first pulse sample on rom_addr one clock after start is sampled.
// Backpressure: none; free-running at the sample clock, start ignored while busy.
module lfm_pulse_addr_gen
    import lfm_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [PHASE_W-1:0] f0_word,
    input  logic [PHASE_W-1:0] k_word,
    input  logic [CNT_W-1:0]   pulse_len,
    input  logic [CNT_W-1:0]   prt_len,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               dac_en,
    output logic               pulse_start,
    output logic               busy,
    output logic               cfg_err
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   prt_cnt;
    logic [CNT_W-1:0]   pulse_len_q;
    logic [CNT_W-1:0]   prt_len_q;
    logic [PHASE_W-1:0] f0_q;
    logic [PHASE_W-1:0] k_q;
    logic [PHASE_W-1:0] f0_load;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;
    logic               cont_q;
    logic               stop_pending;
    logic               cfg_ok;
    logic               start_ok;
    logic               last_pulse;
    logic               last_prt;
    logic               restart;
    logic               acc_load;
    logic               acc_en;

    // Only the top ADDR_W phase bits address the ROM.
    logic unused_phase;
    assign unused_phase = ^{phase, phase_nxt[PHASE_W-ADDR_W-1:0]};

    always_comb begin
        cfg_ok     = (pulse_len != '0) && (prt_len > pulse_len);
        start_ok   = (state == ST_IDLE) && start && cfg_ok;
        last_pulse = (prt_cnt == pulse_len_q - CNT_W'(1));
        last_prt   = (prt_cnt == prt_len_q - CNT_W'(1));
        // A stop arriving on the final gap clock still ends the run at this PRT boundary.
        restart    = (state == ST_GAP) && last_prt && cont_q && !stop_pending && !stop;
        acc_load   = start_ok || restart;
        acc_en     = (state == ST_PULSE) && !last_pulse;
        f0_load    = (state == ST_IDLE) ? f0_word : f0_q;

        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_PULSE;
            ST_PULSE: if (last_pulse) state_nxt = ST_GAP;
            ST_GAP:   if (last_prt) state_nxt = restart ? ST_PULSE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    lfm_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (acc_load),
        .en        (acc_en),
        .f0        (f0_load),
        .k         (k_q),
        .phase     (phase),
        .phase_nxt (phase_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            prt_cnt      <= '0;
            pulse_len_q  <= '0;
            prt_len_q    <= '0;
            f0_q         <= '0;
            k_q          <= '0;
            cont_q       <= 1'b0;
            stop_pending <= 1'b0;
            rom_addr     <= '0;
            dac_en       <= 1'b0;
            pulse_start  <= 1'b0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_ok) begin
                pulse_len_q <= pulse_len;
                prt_len_q   <= prt_len;
                f0_q        <= f0_word;
                k_q         <= k_word;
                cont_q      <= continuous;
            end

            if (acc_load || state_nxt == ST_IDLE)
                prt_cnt <= '0;
            else
                prt_cnt <= prt_cnt + CNT_W'(1);

            if (state_nxt == ST_IDLE)
                stop_pending <= 1'b0;
            else if (stop && state != ST_IDLE)
                stop_pending <= 1'b1;

            rom_addr    <= (state_nxt == ST_PULSE) ? phase_nxt[PHASE_W-1 -: ADDR_W] : '0;
            dac_en      <= (state_nxt == ST_PULSE);
            busy        <= (state_nxt != ST_IDLE);
            pulse_start <= acc_load;
            cfg_err     <= (state == ST_IDLE) && start && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_lfm_pulse_addr_gen.sv
// Directed bench for lfm_pulse_addr_gen: closed-form phase model plus literal address pins.
module tb_lfm_pulse_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [31:0] f0_word;
    logic [31:0] k_word;
    logic [15:0] pulse_len;
    logic [15:0] prt_len;
    logic [10:0] rom_addr;
    logic        dac_en;
    logic        pulse_start;
    logic        busy;
    logic        cfg_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfm_pulse_addr_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .f0_word     (f0_word),
        .k_word      (k_word),
        .pulse_len   (pulse_len),
        .prt_len     (prt_len),
        .rom_addr    (rom_addr),
        .dac_en      (dac_en),
        .pulse_start (pulse_start),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    // Reference model: position within the PRT plus the closed-form chirp phase.
    logic        m_active, m_stop, m_cont, m_err, m_ps;
    int          m_t, m_pl, m_prt;
    logic [31:0] m_f0, m_k;

    function automatic logic [10:0] model_addr(int i, logic [31:0] f0, logic [31:0] k);
        logic [31:0] tri_n;
        logic [31:0] ph;
        tri_n = (i == 0) ? 32'd0 : 32'(i * (i - 1) / 2);
        ph    = 32'(i) * f0 + k * tri_n;
        return ph[31:21];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_stop <= 1'b0; m_cont <= 1'b0; m_err <= 1'b0; m_ps <= 1'b0;
            m_t <= 0; m_pl <= 0; m_prt <= 0; m_f0 <= '0; m_k <= '0;
        end else begin
            m_err <= 1'b0;
            m_ps  <= 1'b0;
            if (!m_active) begin
                if (start && (pulse_len == 16'd0 || prt_len <= pulse_len)) begin
                    m_err <= 1'b1;
                end else if (start) begin
                    m_active <= 1'b1; m_t <= 0; m_ps <= 1'b1;
                    m_f0 <= f0_word; m_k <= k_word; m_cont <= continuous;
                    m_pl <= int'(pulse_len); m_prt <= int'(prt_len);
                end
            end else if (m_t == m_prt - 1) begin
                if (m_cont && !m_stop && !stop) begin
                    m_t <= 0; m_ps <= 1'b1;
                end else begin
                    m_active <= 1'b0; m_stop <= 1'b0; m_t <= 0;
                end
            end else begin
                m_t <= m_t + 1;
                if (stop) m_stop <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick();
        logic        e_dac;
        logic [10:0] e_addr;
        @(negedge clk);
        e_dac  = m_active && (m_t < m_pl);
        e_addr = e_dac ? model_addr(m_t, m_f0, m_k) : 11'd0;
        check("model_busy",        {31'd0, busy},        {31'd0, m_active});
        check("model_dac_en",      {31'd0, dac_en},      {31'd0, e_dac});
        check("model_rom_addr",    {21'd0, rom_addr},    {21'd0, e_addr});
        check("model_pulse_start", {31'd0, pulse_start}, {31'd0, m_ps});
        check("model_cfg_err",     {31'd0, cfg_err},     {31'd0, m_err});
    endtask

    // Drive a config with a one-clock start; returns at the edge showing the first sample.
    task automatic launch(input logic [31:0] f0, input logic [31:0] k,
                          input logic [15:0] pl, input logic [15:0] prt, input logic cont);
        f0_word = f0; k_word = k; pulse_len = pl; prt_len = prt; continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            tick();
        end
        check("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    logic [10:0] tone_lit [4]  = '{11'd0, 11'd204, 11'd408, 11'd612};
    logic [10:0] chirp_lit [6] = '{11'd0, 11'd0, 11'd1, 11'd3, 11'd6, 11'd10};
    logic [10:0] down_lit [4]  = '{11'd0, 11'd8, 11'd15, 11'd21};

    initial begin
        int n_ps;
        int n_busy;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        f0_word = '0; k_word = '0; pulse_len = '0; prt_len = '0;
        tick();
        check("reset_rom_addr", {21'd0, rom_addr}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Tone pulse
        launch(32'h1980_0000, 32'd0, 16'd4, 16'd8, 1'b0);
        check("tone_pulse_start_first", {31'd0, pulse_start}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("tone_rom_addr", {21'd0, rom_addr}, (i < 4) ? {21'd0, tone_lit[i]} : 32'd0);
            check("tone_dac_en", {31'd0, dac_en}, (i < 4) ? 32'd1 : 32'd0);
            check("tone_busy", {31'd0, busy}, 32'd1);
            if (i > 0) check("tone_pulse_start_once", {31'd0, pulse_start}, 32'd0);
            tick();
        end
        check("tone_idle_after_prt", {31'd0, busy}, 32'd0);
        tick();

        // Up-chirp, then extended to show address wrap
        launch(32'd0, 32'h0020_0000, 16'd6, 16'd10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("chirp_rom_addr", {21'd0, rom_addr}, {21'd0, chirp_lit[i]});
            tick();
        end
        wait_idle();
        tick();
        launch(32'd0, 32'h0020_0000, 16'd70, 16'd80, 1'b0);
        repeat (65) tick();
        check("chirp_wrap_s65", {21'd0, rom_addr}, 32'd32);
        repeat (4) tick();
        check("chirp_wrap_s69", {21'd0, rom_addr}, 32'd298);
        check("chirp_dac_s69", {31'd0, dac_en}, 32'd1);
        wait_idle();
        tick();

        // Continuous with stop mid-pulse of third PRT
        launch(32'h1980_0000, 32'd0, 16'd3, 16'd5, 1'b1);
        n_ps = 1; n_busy = 1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 5 || c == 10) check("cont_pulse_start_period", {31'd0, pulse_start}, 32'd1);
            if (c == 11) stop = 1'b1;
            if (c == 12) stop = 1'b0;
            n_ps   += int'(pulse_start);
            n_busy += int'(busy);
        end
        check("cont_pulse_start_count", 32'(n_ps), 32'd3);
        check("cont_busy_cycles", 32'(n_busy), 32'd15);

        // start and stop together in IDLE: stop is dropped, run keeps repeating
        stop = 1'b1;
        launch(32'h1980_0000, 32'd0, 16'd3, 16'd5, 1'b1);
        stop = 1'b0;
        repeat (10) tick();
        check("startstop_third_prt", {31'd0, pulse_start}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle();
        tick();

        // Config errors
        launch(32'h1980_0000, 32'd0, 16'd8, 16'd8, 1'b0);
        check("cfg_err_equal_len", {31'd0, cfg_err}, 32'd1);
        check("cfg_err_equal_busy", {31'd0, busy}, 32'd0);
        check("cfg_err_equal_addr", {21'd0, rom_addr}, 32'd0);
        tick();
        check("cfg_err_one_clock", {31'd0, cfg_err}, 32'd0);
        launch(32'h1980_0000, 32'd0, 16'd0, 16'd8, 1'b0);
        check("cfg_err_zero_len", {31'd0, cfg_err}, 32'd1);
        check("cfg_err_zero_busy", {31'd0, busy}, 32'd0);
        tick();

        // Reset at pulse sample 2
        launch(32'h1980_0000, 32'd0, 16'd4, 16'd8, 1'b0);
        tick();
        tick();
        check("rst_pre_sample2", {21'd0, rom_addr}, 32'd408);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_dac_en", {31'd0, dac_en}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_rom_addr", {21'd0, rom_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        launch(32'h1980_0000, 32'd0, 16'd4, 16'd8, 1'b0);
        check("rst_restart_addr", {21'd0, rom_addr}, 32'd0);
        check("rst_restart_dac_en", {31'd0, dac_en}, 32'd1);
        wait_idle();
        tick();

        // Down-chirp with a start pulsed mid-PRT
        launch(32'h0100_0000, 32'hFFE0_0000, 16'd4, 16'd8, 1'b0);
        check("down_rom_addr0", {21'd0, rom_addr}, {21'd0, down_lit[0]});
        tick();
        check("down_rom_addr1", {21'd0, rom_addr}, {21'd0, down_lit[1]});
        pulse_len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("down_rom_addr2", {21'd0, rom_addr}, {21'd0, down_lit[2]});
        check("busy_start_no_err", {31'd0, cfg_err}, 32'd0);
        check("busy_start_no_restart", {31'd0, pulse_start}, 32'd0);
        tick();
        check("down_rom_addr3", {21'd0, rom_addr}, {21'd0, down_lit[3]});
        check("down_dac_s3", {31'd0, dac_en}, 32'd1);
        wait_idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
